enc_pack_sequencer: RTL and testbench
=====================================

# enc_pack_sequencer

Sequencer for the encoder's bank of binder packs. For each input sample it steps through NUM_PACKS binder packs in order, fetching each pack's level hypervectors, firing that pack's binders for one cycle, waiting out the binder latency, and handing the shifted result to the bundler under a valid/ready handshake. It sits between the level-HV fetch logic, the binder packs, and the downstream bundler.

## Interface
- NUM_PACKS, 5: number of binder packs; the full feature count is NUM_PACKS × FEATURES_PER_CC.
- BIND_LATENCY, 1: cycles from a binder start until its shifted_hv is valid; must be ≥1.
- PIDX_W, $clog2(NUM_PACKS) (localparam, min 1): pack index width.

Ports:
- clk  in  1  clock.
- nrst  in  1  asynchronous, active-low reset.
- start_sample  in  1  pulse that begins encoding one sample; ignored while busy.
- abort  in  1  synchronous abort; returns the block to IDLE.
- busy  out  1  high in every state except IDLE.
- sample_done  out  1  one-cycle pulse after the last pack is accepted.
- lvl_req  out  1  requests the level HVs for lvl_pack_idx.
- lvl_ack  in  1  level HVs are present on the pack inputs.
- lvl_pack_idx  out  PIDX_W  index of the current pack.
- start_encoding  out  1  one-cycle binder start, shared by all packs.
- pack_en  out  NUM_PACKS  one-hot pack enable, qualified by start_encoding.
- bnd_valid  out  1  the current pack's shifted HVs are valid.
- bnd_last  out  1  marks the final pack of the sample; meaningful only with bnd_valid.
- bnd_ready  in  1  bundler accepts the data.

## Operation
- States: IDLE, FETCH, BIND, WAIT, EMIT.
- IDLE: when start_sample is 1, set pack_idx to 0 and go to FETCH.
- FETCH:
  - lvl_req is 1.
  - When lvl_ack is sampled 1, go to BIND.
  - lvl_req stays high until the ack.
  - An ack outside FETCH is ignored.
- BIND:
  - Lasts exactly one cycle.
  - start_encoding is 1 and pack_en = 1<<pack_idx.
  - Go to WAIT with the latency counter loaded to BIND_LATENCY−1.
- WAIT:
  - Decrement the counter each cycle.
  - When the counter is 0, go to EMIT.
  - WAIT therefore lasts BIND_LATENCY cycles.
- EMIT:
  - bnd_valid is 1 and bnd_last = (pack_idx == NUM_PACKS−1).
  - Hold both until bnd_ready is 1.
  - On a handshake when not last: increment pack_idx and go to FETCH.
  - On a handshake when last: go to IDLE and pulse sample_done in the next cycle.
- Outputs:
  - All control outputs are Moore outputs decoded from the registered state; there is no combinational path from any input to any output.
  - pack_en is all-zero outside BIND.
  - lvl_pack_idx always equals pack_idx. Its value in IDLE is don't-care but stable.
- Abort:
  - Takes priority over every transition.
  - The next state is IDLE, with pack_idx and the counter cleared.
  - sample_done is not pulsed.
- start_sample and abort in the same cycle while in IDLE: abort wins and the block stays in IDLE.
- pack_idx never wraps. The last-pack check is exact even when NUM_PACKS is not a power of two.

## Timing
- Reset values:
  - State is IDLE; pack_idx and the counter are 0.
  - busy, sample_done, lvl_req, start_encoding, pack_en, bnd_valid and bnd_last are all 0.
- Per pack, with lvl_ack and bnd_ready already high: 1 (FETCH) + 1 (BIND) + BIND_LATENCY (WAIT) + 1 (EMIT) = 3+BIND_LATENCY cycles.
- Per sample, with no stalls: NUM_PACKS × (3+BIND_LATENCY) cycles from the first FETCH; sample_done follows one cycle after the last handshake.
- start_sample sampled in cycle t gives lvl_req = 1 in cycle t+1.
- busy falls in the same cycle that sample_done rises.
- A new start_sample may be accepted in the sample_done cycle.
- Reset asserted mid-sample forces every output to its reset value immediately; there is no resume.

## Structure
- The shared HDC encoder package holds NUM_PACKS (alongside FEATURES_PER_CC, HV_DIM and SHIFTS) and the typedef enc_seq_state_t for the five-state enum.
- Single module with no sub-modules; the one-hot decode and the latency counter are inline.

## Test plan
- Reset, then one sample with NUM_PACKS=5, BIND_LATENCY=1, ack and ready tied high:
  - exactly 5 start_encoding pulses;
  - pack_en sequence 00001, 00010, 00100, 01000, 10000;
  - sample_done in cycle 21 after start_sample;
  - bnd_last only on the 5th bnd_valid.
- Random lvl_ack and bnd_ready stalls (0–7 cycles):
  - lvl_req and bnd_valid stay high until their handshake;
  - no extra start_encoding pulses;
  - data order is preserved.
- BIND_LATENCY=3:
  - bnd_valid rises exactly 4 cycles after each start_encoding;
  - the per-pack period with no stalls is 6 cycles.
- abort asserted in FETCH, WAIT and EMIT of pack 2:
  - busy is 0 in the next cycle and no sample_done;
  - the following start_sample restarts at pack 0.
- start_sample pulsed while busy: ignored, still only 5 packs and 1 sample_done. Back-to-back start on the sample_done cycle: the second sample begins with lvl_req one cycle later.
- nrst asserted during WAIT: all outputs are 0 immediately. After release, with NUM_PACKS=3, the sample completes in 3 × 4 cycles.

Source files
------------

// File: rtl/enc_pack_sequencer_pkg.sv
// Shared HDC encoder definitions: pack geometry, hypervector sizing and the
// pack-sequencer state encoding.
package enc_pack_sequencer_pkg;

    localparam int NUM_PACKS       = 5;
    localparam int FEATURES_PER_CC = 8;
    localparam int HV_DIM          = 1024;
    localparam int SHIFTS          = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_BIND  = 3'd2,
        ST_WAIT  = 3'd3,
        ST_EMIT  = 3'd4
    } enc_seq_state_t;

    // Index/counter width that never collapses to zero bits.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/enc_pack_sequencer.sv
// Steps one sample through every binder pack: fetch level HVs, fire the pack's
// binders, wait out the binder latency, then hand the result to the bundler.
module enc_pack_sequencer #(
    parameter int  NUM_PACKS    = enc_pack_sequencer_pkg::NUM_PACKS,
    parameter int  BIND_LATENCY = 1,
    localparam int PIDX_W       = enc_pack_sequencer_pkg::clog2_min1(NUM_PACKS)
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic                 start_sample,
    input  logic                 abort,
    output logic                 busy,
    output logic                 sample_done,
    output logic                 lvl_req,
    input  logic                 lvl_ack,
    output logic [PIDX_W-1:0]    lvl_pack_idx,
    output logic                 start_encoding,
    output logic [NUM_PACKS-1:0] pack_en,
    output logic                 bnd_valid,
    output logic                 bnd_last,
    input  logic                 bnd_ready
);
    import enc_pack_sequencer_pkg::*;

    localparam int CNT_W = clog2_min1(BIND_LATENCY);

    enc_seq_state_t       state_q, state_d;
    logic [PIDX_W-1:0]    pack_idx_q, pack_idx_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 busy_q, busy_d;
    logic                 sample_done_q, sample_done_d;
    logic                 lvl_req_q, lvl_req_d;
    logic                 start_encoding_q, start_encoding_d;
    logic [NUM_PACKS-1:0] pack_en_q, pack_en_d;
    logic                 bnd_valid_q, bnd_valid_d;
    logic                 bnd_last_q, bnd_last_d;
    logic                 is_last;

    assign is_last = (pack_idx_q == PIDX_W'(NUM_PACKS - 1));

    always_comb begin
        state_d       = state_q;
        pack_idx_d    = pack_idx_q;
        cnt_d         = cnt_q;
        sample_done_d = 1'b0;
        if (abort) begin
            state_d    = ST_IDLE;
            pack_idx_d = '0;
            cnt_d      = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_sample) begin
                        state_d    = ST_FETCH;
                        pack_idx_d = '0;
                    end
                end
                ST_FETCH: begin
                    if (lvl_ack) state_d = ST_BIND;
                end
                ST_BIND: begin
                    state_d = ST_WAIT;
                    cnt_d   = CNT_W'(BIND_LATENCY - 1);
                end
                ST_WAIT: begin
                    if (cnt_q == '0) state_d = ST_EMIT;
                    else             cnt_d   = cnt_q - CNT_W'(1);
                end
                ST_EMIT: begin
                    if (bnd_ready) begin
                        if (is_last) begin
                            state_d       = ST_IDLE;
                            sample_done_d = 1'b1;
                        end else begin
                            state_d    = ST_FETCH;
                            pack_idx_d = pack_idx_q + PIDX_W'(1);
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        // Outputs are decoded from the next state so they appear as flops.
        busy_d           = (state_d != ST_IDLE);
        lvl_req_d        = (state_d == ST_FETCH);
        start_encoding_d = (state_d == ST_BIND);
        pack_en_d        = (state_d == ST_BIND) ? (NUM_PACKS'(1) << pack_idx_d) : '0;
        bnd_valid_d      = (state_d == ST_EMIT);
        bnd_last_d       = (state_d == ST_EMIT) && (pack_idx_d == PIDX_W'(NUM_PACKS - 1));
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q          <= ST_IDLE;
            pack_idx_q       <= '0;
            cnt_q            <= '0;
            busy_q           <= 1'b0;
            sample_done_q    <= 1'b0;
            lvl_req_q        <= 1'b0;
            start_encoding_q <= 1'b0;
            pack_en_q        <= '0;
            bnd_valid_q      <= 1'b0;
            bnd_last_q       <= 1'b0;
        end else begin
            state_q          <= state_d;
            pack_idx_q       <= pack_idx_d;
            cnt_q            <= cnt_d;
            busy_q           <= busy_d;
            sample_done_q    <= sample_done_d;
            lvl_req_q        <= lvl_req_d;
            start_encoding_q <= start_encoding_d;
            pack_en_q        <= pack_en_d;
            bnd_valid_q      <= bnd_valid_d;
            bnd_last_q       <= bnd_last_d;
        end
    end

    assign busy           = busy_q;
    assign sample_done    = sample_done_q;
    assign lvl_req        = lvl_req_q;
    assign lvl_pack_idx   = pack_idx_q;
    assign start_encoding = start_encoding_q;
    assign pack_en        = pack_en_q;
    assign bnd_valid      = bnd_valid_q;
    assign bnd_last       = bnd_last_q;

endmodule

// File: tb/tb_enc_pack_sequencer.sv
// Directed and table-driven checks of the pack sequencer (5 packs / latency 1,
// plus a 3-pack / latency-3 instance).
module tb_enc_pack_sequencer;

    logic       clk, nrst;
    logic       start_sample, abort, lvl_ack, bnd_ready;
    logic       busy, sample_done, lvl_req, start_encoding, bnd_valid, bnd_last;
    logic [4:0] pack_en;
    logic [2:0] lvl_pack_idx;

    logic       start3, abort3, ack3, rdy3;
    logic       busy3, done3, req3, se3, valid3, last3;
    logic [2:0] pen3;
    logic [1:0] idx3;

    int n_vec = 0;
    int n_err = 0;

    enc_pack_sequencer #(.NUM_PACKS(5), .BIND_LATENCY(1)) dut (
        .clk(clk), .nrst(nrst), .start_sample(start_sample), .abort(abort),
        .busy(busy), .sample_done(sample_done), .lvl_req(lvl_req), .lvl_ack(lvl_ack),
        .lvl_pack_idx(lvl_pack_idx), .start_encoding(start_encoding), .pack_en(pack_en),
        .bnd_valid(bnd_valid), .bnd_last(bnd_last), .bnd_ready(bnd_ready)
    );

    enc_pack_sequencer #(.NUM_PACKS(3), .BIND_LATENCY(3)) dut3 (
        .clk(clk), .nrst(nrst), .start_sample(start3), .abort(abort3),
        .busy(busy3), .sample_done(done3), .lvl_req(req3), .lvl_ack(ack3),
        .lvl_pack_idx(idx3), .start_encoding(se3), .pack_en(pen3),
        .bnd_valid(valid3), .bnd_last(last3), .bnd_ready(rdy3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       st, ab, ack, rdy;
        logic [13:0] exp;
    } vec_t;

    function automatic logic [13:0] mk(input logic b, input logic d, input logic r,
                                       input logic s, input logic v, input logic l,
                                       input logic [4:0] pen, input logic [2:0] idx);
        return {b, d, r, s, v, l, pen, idx};
    endfunction

    function automatic logic [13:0] outs();
        return {busy, sample_done, lvl_req, start_encoding, bnd_valid, bnd_last,
                pack_en, lvl_pack_idx};
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Entered on cycle 1 of a sample (FETCH of pack 0 visible); returns on the
    // sample_done cycle without advancing the clock.
    task automatic run_main(input bit stalls, input bit spur, output int done_cyc);
        int  n_se = 0, n_hs = 0, n_last = 0, exp_idx = 0;
        int  ack_wait, rdy_wait, n;
        bit  req_pend = 0, val_pend = 0, done = 0;
        ack_wait = stalls ? int'($urandom_range(0, 7)) : 0;
        rdy_wait = stalls ? int'($urandom_range(0, 7)) : 0;
        done_cyc = -1;
        n = 1;
        while (!done && n < 400) begin
            if (req_pend) check("lvl_req_hold", lvl_req, 1);
            if (val_pend) check("bnd_valid_hold", bnd_valid, 1);
            if (start_encoding) begin
                n_se++;
                check("pack_en", pack_en, 32'd1 << exp_idx);
            end
            if (sample_done) begin
                done = 1;
                done_cyc = n;
                check("busy_at_done", busy, 0);
            end else begin
                lvl_ack = 1'b0;
                if (lvl_req) begin
                    if (ack_wait == 0) lvl_ack = 1'b1;
                    else ack_wait--;
                end
                req_pend = lvl_req && !lvl_ack;
                if (lvl_req && lvl_ack) ack_wait = stalls ? int'($urandom_range(0, 7)) : 0;
                bnd_ready = 1'b0;
                if (bnd_valid) begin
                    if (rdy_wait == 0) bnd_ready = 1'b1;
                    else rdy_wait--;
                end
                val_pend = bnd_valid && !bnd_ready;
                if (bnd_valid && bnd_ready) begin
                    check("hs_idx", lvl_pack_idx, exp_idx);
                    check("hs_last", bnd_last, (exp_idx == 4) ? 1 : 0);
                    if (bnd_last) n_last++;
                    n_hs++;
                    exp_idx++;
                    rdy_wait = stalls ? int'($urandom_range(0, 7)) : 0;
                end
                start_sample = spur && (n % 7 == 3);
                tick();
                n++;
            end
        end
        start_sample = 1'b0;
        lvl_ack      = 1'b0;
        bnd_ready    = 1'b0;
        check("sample_done_seen", done, 1);
        check("start_enc_count", n_se, 5);
        check("handshake_count", n_hs, 5);
        check("last_count", n_last, 1);
    endtask

    // Runs pack 0..2 with ack/ready high until the named phase of pack 2, aborts,
    // and confirms a clean restart at pack 0.
    task automatic abort_in(input int phase);
        bit found = 0;
        start_sample = 1'b1;
        tick();
        start_sample = 1'b0;
        lvl_ack   = 1'b1;
        bnd_ready = 1'b1;
        for (int i = 0; i < 40 && !found; i++) begin
            if (lvl_pack_idx == 3'd2 &&
                ((phase == 0 && lvl_req) ||
                 (phase == 1 && busy && !lvl_req && !start_encoding && !bnd_valid) ||
                 (phase == 2 && bnd_valid)))
                found = 1;
            else
                tick();
        end
        check("abort_reach", found, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        lvl_ack   = 1'b0;
        bnd_ready = 1'b0;
        check("abort_busy_done", {busy, sample_done}, 0);
        tick();
        check("abort_no_done", {busy, sample_done}, 0);
        start_sample = 1'b1;
        tick();
        start_sample = 1'b0;
        check("abort_restart", {lvl_req, lvl_pack_idx}, {1'b1, 3'd0});
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    vec_t vecs[15];

    initial begin
        int dc;
        int s_cyc[3], v_cyc[3];
        int n_s3, n_v3;
        logic [2:0] last_mask;
        bit done_seen;

        //           st    ab    ack   rdy   busy done req se val last pen idx
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 0, 5'b00000, 3'd0)};
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 0, 5'b00000, 3'd0)};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, mk(1, 0, 1, 0, 0, 0, 5'b00000, 3'd0)};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, mk(1, 0, 1, 0, 0, 0, 5'b00000, 3'd0)};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, mk(1, 0, 0, 1, 0, 0, 5'b00001, 3'd0)};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, mk(1, 0, 0, 0, 0, 0, 5'b00000, 3'd0)};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, mk(1, 0, 0, 0, 1, 0, 5'b00000, 3'd0)};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, mk(1, 0, 0, 0, 1, 0, 5'b00000, 3'd0)};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, mk(1, 0, 1, 0, 0, 0, 5'b00000, 3'd1)};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, mk(1, 0, 0, 1, 0, 0, 5'b00010, 3'd1)};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 1'b0, mk(1, 0, 0, 0, 0, 0, 5'b00000, 3'd1)};
        vecs[11] = '{1'b1, 1'b0, 1'b1, 1'b0, mk(1, 0, 0, 0, 1, 0, 5'b00000, 3'd1)};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b1, mk(0, 0, 0, 0, 0, 0, 5'b00000, 3'd0)};
        vecs[13] = '{1'b1, 1'b0, 1'b0, 1'b0, mk(1, 0, 1, 0, 0, 0, 5'b00000, 3'd0)};
        vecs[14] = '{1'b0, 1'b1, 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 0, 5'b00000, 3'd0)};

        nrst = 1'b0;
        start_sample = 1'b0; abort = 1'b0; lvl_ack = 1'b0; bnd_ready = 1'b0;
        start3 = 1'b0; abort3 = 1'b0; ack3 = 1'b1; rdy3 = 1'b1;
        tick();
        tick();
        check("reset_outs", outs(), 0);
        nrst = 1'b1;
        tick();

        foreach (vecs[i]) begin
            start_sample = vecs[i].st;
            abort        = vecs[i].ab;
            lvl_ack      = vecs[i].ack;
            bnd_ready    = vecs[i].rdy;
            tick();
            if (outs() !== vecs[i].exp) begin
                n_err++;
                $display("FAIL vec%0d: got %b expected %b", i, outs(), vecs[i].exp);
            end
            n_vec++;
        end
        start_sample = 1'b0; abort = 1'b0; lvl_ack = 1'b0; bnd_ready = 1'b0;
        tick();

        // Clean sample, then a back-to-back start taken on the sample_done cycle.
        start_sample = 1'b1;
        tick();
        start_sample = 1'b0;
        check("first_lvl_req", lvl_req, 1);
        run_main(0, 0, dc);
        check("done_cycle", dc, 21);
        start_sample = 1'b1;
        tick();
        start_sample = 1'b0;
        check("b2b_start", {lvl_req, lvl_pack_idx, sample_done}, {1'b1, 3'd0, 1'b0});
        run_main(1, 1, dc);
        tick();
        check("single_done", {busy, sample_done}, 0);

        abort_in(0);
        abort_in(1);
        abort_in(2);

        // Reset while waiting on pack 1's binders.
        start_sample = 1'b1;
        tick();
        start_sample = 1'b0;
        lvl_ack = 1'b1; bnd_ready = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 40 && !done_seen; i++) begin
            if (lvl_pack_idx == 3'd1 && busy && !lvl_req && !start_encoding && !bnd_valid)
                done_seen = 1;
            else
                tick();
        end
        check("reach_wait", done_seen, 1);
        nrst = 1'b0;
        #1;
        check("async_reset_outs", outs(), 0);
        lvl_ack = 1'b0; bnd_ready = 1'b0;
        #2;
        nrst = 1'b1;
        tick();
        check("post_reset_idle", outs(), 0);
        start_sample = 1'b1;
        tick();
        start_sample = 1'b0;
        run_main(0, 0, dc);
        check("post_reset_done_cycle", dc, 21);
        tick();

        // 3 packs, latency 3: start_encoding to bnd_valid is 4 cycles, period 6.
        n_s3 = 0; n_v3 = 0; last_mask = '0; dc = -1;
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        for (int n = 1; n < 60 && dc < 0; n++) begin
            if (se3 && n_s3 < 3) begin s_cyc[n_s3] = n; n_s3++; end
            if (valid3 && n_v3 < 3) begin
                last_mask[n_v3] = last3;
                v_cyc[n_v3] = n;
                n_v3++;
            end
            if (done3) dc = n;
            else tick();
        end
        check("l3_se_count", n_s3, 3);
        check("l3_valid_count", n_v3, 3);
        check("l3_done_cycle", dc, 19);
        check("l3_last_mask", last_mask, 3'b100);
        for (int i = 0; i < 3; i++)
            if (i < n_s3 && i < n_v3) check("l3_bind_to_valid", v_cyc[i] - s_cyc[i], 4);
        for (int i = 0; i < 2; i++)
            if (i + 1 < n_s3) check("l3_period", s_cyc[i+1] - s_cyc[i], 6);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
